// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: clocked request/response front end for the combinational ALU.
// A request is accepted on a valid/ready handshake and its operands are held on
// the ALU inputs. After SETTLE extra cycles the ALU result is captured, together
// with its opcode, into a small response FIFO that the consumer drains.
//
// state | meaning
// IDLE  | ready for a new request when the response FIFO has room
// WAIT  | ALU inputs driven, settle counter running down to zero
// CAPT  | ALU output is captured into the FIFO this cycle
module alu_req_ctrl #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [OPW-1:0]   rsp_op,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] OCC_FULL  = (AW+1)'(DEPTH);
    localparam logic [3:0]  SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [OPW-1:0]   fifo_op   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             accept;
    logic             push;
    logic             pop;

    // Occupancy is checked at accept time, so a capture always finds a free slot.
    assign accept    = req_valid && req_ready;
    assign push      = (state == CAPT);
    assign pop       = rsp_ready && rsp_valid;
    assign busy      = (state != IDLE);
    assign rsp_valid = (occ != '0);
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_op    = fifo_op[rd_ptr];

    // Next-state and ready decode; ready depends on state and occupancy only.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = (occ < OCC_FULL);
                if (req_valid && (occ < OCC_FULL)) begin
                    state_nxt = (SETTLE == 0) ? CAPT : WAIT;
                end
            end
            WAIT: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, operand latches, settle timer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            done_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_op     <= req_op;
                settle_cnt <= SETTLE_LD;
            end else if ((state == WAIT) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (push) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    // Response FIFO: registered storage, head read through the read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_op[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= alu_out;
                fifo_op[wr_ptr]   <= alu_op;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (AW+1)'(1);
            end else if (!push && pop) begin
                occ <= occ - (AW+1)'(1);
            end
        end
    end

endmodule
